// File: rtl/mux4.sv
// Four-way data selector with a combinational output and an enabled, registered copy.
// Define MUX4_PARITY_EN to add the y_par output (even parity of y_q).
module mux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       s_q,
  output logic             vld_q
`ifdef MUX4_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic [1:0]       r_s_q;
  logic             r_vld_q;

  // Unknown select values fall through to the default and drive zero.
  always_comb begin
    w_y = '0;
    case (s)
      2'b00:   w_y = d0;
      2'b01:   w_y = d1;
      2'b10:   w_y = d2;
      2'b11:   w_y = d3;
      default: w_y = '0;
    endcase
  end

  // Synchronous reset wins over the load enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q   <= '0;
      r_s_q   <= 2'b00;
      r_vld_q <= 1'b0;
    end else if (en) begin
      r_y_q   <= w_y;
      r_s_q   <= s;
      r_vld_q <= 1'b1;
    end
  end

`ifdef MUX4_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (en) begin
      r_par <= ^w_y;
    end
  end

  assign y_par = r_par;
`endif

  assign y     = w_y;
  assign y_q   = r_y_q;
  assign s_q   = r_s_q;
  assign vld_q = r_vld_q;

endmodule

// File: tb/tb_mux4.sv
// Bench for mux4: vector table for the combinational path, scoreboard queue for the registered path.
module tb_mux4;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [1:0]       s;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       s_q;
  logic             vld_q;
`ifdef MUX4_PARITY_EN
  logic             y_par;
`endif

  mux4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .s     (s),
    .en    (en),
    .y     (y),
    .y_q   (y_q),
    .s_q   (s_q),
    .vld_q (vld_q)
`ifdef MUX4_PARITY_EN
    ,
    .y_par (y_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [1:0]       s;
    logic [WIDTH-1:0] y;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic [1:0]       s;
    logic             par;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_sel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                                               input logic [1:0] sel);
    case (sel)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return d;
    endcase
  endfunction

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d, input logic [1:0] sel);
    d0 = a; d1 = b; d2 = c; d3 = d; s = sel;
  endtask

  // Drive a load at the falling edge, record the expectation, then compare after the rising edge.
  task automatic load_and_check(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d, input logic [1:0] sel);
    exp_t e;
    @(negedge clk);
    drive(a, b, c, d, sel);
    en = 1'b1;
    e.y   = ref_sel(a, b, c, d, sel);
    e.s   = sel;
    e.par = ^e.y;
    sb.push_back(e);
    @(posedge clk);
    #1;
    en = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".y_q"}, 64'(y_q), 64'(e.y));
      chk({name, ".s_q"}, 64'(s_q), 64'(e.s));
      chk({name, ".vld_q"}, 64'(vld_q), 64'(1'b1));
`ifdef MUX4_PARITY_EN
      chk({name, ".y_par"}, 64'(y_par), 64'(e.par));
`endif
    end
  endtask

  initial begin
    logic [WIDTH-1:0] held;

    vecs[0] = '{32'h000000FF, 32'h0, 32'h0, 32'h0, 2'b00, 32'h000000FF};
    vecs[1] = '{32'h000000FF, 32'h0, 32'h0, 32'h0, 2'b01, 32'h0};
    vecs[2] = '{32'h000000FF, 32'h0, 32'h0, 32'h0, 2'b10, 32'h0};
    vecs[3] = '{32'h000000FF, 32'h0, 32'h0, 32'h0, 2'b11, 32'h0};
    vecs[4] = '{32'h0, 32'h0000FF00, 32'h0, 32'h0, 2'b01, 32'h0000FF00};
    vecs[5] = '{32'h0, 32'h0, 32'h00FF0000, 32'h0, 2'b10, 32'h00FF0000};
    vecs[6] = '{32'h0, 32'h0, 32'h0, 32'hFF000000, 2'b11, 32'hFF000000};
    vecs[7] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 2'b10, 32'h33333333};
    vecs[8] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 2'b01, 32'h0};
    vecs[9] = '{32'h80000001, 32'h7FFFFFFE, 32'h0, 32'hDEADBEEF, 2'b00, 32'h80000001};

    rst_n = 1'b0;
    en    = 1'b1;
    drive(32'hCAFEF00D, 32'h12345678, 32'h0, 32'h0, 2'b01);

    // Reset with en high; combinational path stays live meanwhile.
    @(posedge clk);
    @(negedge clk);
    chk("rst.y_q", 64'(y_q), 64'h0);
    chk("rst.s_q", 64'(s_q), 64'h0);
    chk("rst.vld_q", 64'(vld_q), 64'h0);
`ifdef MUX4_PARITY_EN
    chk("rst.y_par", 64'(y_par), 64'h0);
`endif
    chk("rst.y_live", 64'(y), 64'h12345678);

    // Combinational vectors with en low: y follows immediately, registers hold reset values.
    rst_n = 1'b1;
    en    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].s);
      #1;
      chk($sformatf("vec%0d.y", i), 64'(y), 64'(vecs[i].y));
    end
    @(posedge clk);
    #1;
    chk("noload.vld_q", 64'(vld_q), 64'h0);
    chk("noload.y_q", 64'(y_q), 64'h0);

    // Load, then hold with en low while y keeps following the inputs.
    load_and_check("ld_a5", 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 2'b10);
    @(negedge clk);
    drive(32'h0BADC0DE, 32'h0, 32'hA5A5A5A5, 32'h0, 2'b00);
    #1;
    chk("hold.y", 64'(y), 64'h0BADC0DE);
    @(posedge clk);
    #1;
    chk("hold.y_q", 64'(y_q), 64'hA5A5A5A5);
    chk("hold.s_q", 64'(s_q), 64'h2);
    chk("hold.vld_q", 64'(vld_q), 64'h1);

    // Reset asserted between edges must not touch the registers until the next edge.
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    #1;
    chk("sync.y_q", 64'(y_q), 64'hA5A5A5A5);
    chk("sync.vld_q", 64'(vld_q), 64'h1);
    @(posedge clk);
    #1;
    chk("rst2.y_q", 64'(y_q), 64'h0);
    chk("rst2.s_q", 64'(s_q), 64'h0);
    chk("rst2.vld_q", 64'(vld_q), 64'h0);

    // After release, loading resumes only once en is high.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
    chk("resume.idle_vld", 64'(vld_q), 64'h0);
    load_and_check("resume", 32'h13579BDF, 32'h0, 32'h0, 32'h2468ACE0, 2'b11);

`ifdef MUX4_PARITY_EN
    load_and_check("par7", 32'h00000007, 32'h0, 32'h0, 32'h0, 2'b00);
    chk("par7.bit", 64'(y_par), 64'h1);
    load_and_check("par3", 32'h00000003, 32'h0, 32'h0, 32'h0, 2'b00);
    chk("par3.bit", 64'(y_par), 64'h0);
`endif

    // Random loads through the scoreboard.
    for (int i = 0; i < 20; i++) begin
      load_and_check($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom),
                     WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)));
    end

    // Registers stay stable between edges while inputs toggle.
    held = y_q;
    @(negedge clk);
    drive(~d0, ~d1, ~d2, ~d3, ~s);
    #2;
    chk("stable.y_q", 64'(y_q), 64'(held));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
